week6_ex1_not_pipe: RTL and testbench
=====================================

# week6_ex1_not_pipe

Parametrised, pipelined successor to the single-bit NOT exercise. It is a WIDTH-bit, per-bit maskable inverter behind a DEPTH-stage valid/ready pipeline, and it counts completed output transfers. It sits in the week-6 datapath exercises as the first block with flow control. Its benches reuse the week-5 pass/fail reporting style.

## Interface
Parameters:
- WIDTH, 8, data and mask width in bits (≥1)
- DEPTH, 2, number of register stages, equal to the latency in cycles (≥1)
- COUNT_W, 16, width of the output-transfer counter (≥1)

Ports:
- clk  input  1  single clock, all state updates on rising edge
- rst  input  1  reset, synchronous and active-high
- in_valid  input  1  upstream word present
- in_ready  output  1  block can accept a word this cycle
- in_data  input  WIDTH  input word
- in_mask  input  WIDTH  per-bit invert select: 1 = invert, 0 = pass; sampled together with in_data
- out_valid  output  1  out_data holds a valid word
- out_ready  input  1  downstream accepts the word
- out_data  output  WIDTH  processed word
- out_count  output  COUNT_W  number of completed output transfers, modulo 2^COUNT_W

## Operation
- Transfer rule, both ports: a transfer occurs in a cycle where valid && ready are both high at the rising edge.
- Stages 0..DEPTH-1 each hold a valid bit v[i] and a data register d[i]. Stage DEPTH-1 drives out_valid and out_data.
- Stage i can load when !v[i] or stage i is emptying this cycle.
  - The last stage empties on an output transfer.
  - An inner stage empties when it passes its word to stage i+1.
- in_ready equals the stage-0 load condition. This gives a combinational path from out_ready to in_ready, and the path is permitted.
- Input accept: d[0] <= in_data ^ in_mask and v[0] <= 1.
- Stage advance: d[i+1] <= d[i] and v[i+1] <= 1.
- A stage that empties without reloading clears v. It leaves d unchanged.
- Bubbles collapse. A stalled output never blocks stages behind an empty stage.
- Capacity is DEPTH words. No word is dropped, duplicated or reordered.
- out_count increments by 1 on each output transfer and wraps from 2^COUNT_W−1 to 0.
- Data registers load only on their stage's load event. out_data holds its last value while out_valid=0.
- Mask all-ones gives a bitwise NOT, matching the week-5 behaviour per bit. Mask all-zeros gives pass-through.

## Timing
- Reset, applied at a rising edge with rst=1:
  - all v[i]=0, all d[i]=0
  - out_valid=0, out_data=0, out_count=0
  - in_ready=1 from the first cycle after reset
- Reset mid-stream discards all in-flight words.
  - Any in_valid during reset is ignored.
  - rst has priority over every other event in the same cycle.
- Latency: a word accepted at edge N appears with out_valid=1 after edge N+DEPTH−1, i.e. it is visible in the cycle following that edge, provided no stall occurred.
- Throughput: one word per cycle while out_ready=1.
- Full pipeline (all v=1) with out_ready=0 forces in_ready=0.
- Full pipeline with out_ready=1: in_ready=1, and input accept and output transfer happen in the same cycle.
- Simultaneous input and output transfer on a full pipeline keeps occupancy at DEPTH.
- out_valid must not drop while out_valid=1 and out_ready=0. out_data must stay stable during such a stall.

## Test plan
- WIDTH=8, DEPTH=2, out_ready=1:
  - Stimulus: send 0x00 with mask 0xFF, then 0xA5 with mask 0xFF.
  - Required: out_data 0xFF, then 0x5A, on consecutive cycles starting 2 edges after the first accept; out_count=2.
- Mask mixing:
  - Stimulus: 0x0F with mask 0x00 → 0x0F; 0x0F with mask 0xF0 → 0xFF; 0xFF with mask 0x81 → 0x7E.
  - Required: all three outputs exactly as listed, in order.
- Backpressure:
  - Stimulus: stream 0x01..0x06 with mask 0x00; hold out_ready=0 for 5 cycles, then release.
  - Required: in_ready=0 once 2 words are held; out_data stays 0x01 while stalled; the output sequence is 0x01..0x06 with no loss or duplication.
- Bubbles:
  - Stimulus: in_valid toggled 1,0,1,0 with out_ready toggled 0,1,0,1.
  - Required: every accepted word emerges once, in order; out_count equals the number of accepted words.
- Reset mid-stream:
  - Stimulus: after 2 accepts, assert rst for 1 cycle.
  - Required: next cycle out_valid=0, out_data=0x00, out_count=0, in_ready=1; the next word sent emerges normally.
- Counter wrap:
  - Stimulus: COUNT_W=4, 17 output transfers.
  - Required: out_count reads 15 after the 15th transfer, 0 after the 16th, 1 after the 17th.

Source files
------------

// File: rtl/week6_ex1_not_pipe.sv
// rtl/week6_ex1_not_pipe.sv - maskable inverter behind a DEPTH-stage valid/ready pipeline with transfer counter
module week6_ex1_not_pipe #(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 2,
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [WIDTH-1:0]   in_mask,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [COUNT_W-1:0] out_count
);

  logic [DEPTH-1:0]   v_q, v_d;
  logic [DEPTH-1:0]   load;
  logic [WIDTH-1:0]   d_q [DEPTH];
  logic [WIDTH-1:0]   d_d [DEPTH];
  logic [COUNT_W-1:0] count_q, count_d;
  logic               out_fire;

  // Stage i can load if it or any stage downstream of it has a hole, or the output drains;
  // this is what lets bubbles collapse behind a stalled output.
  always_comb begin
    logic ld;
    ld   = out_ready;
    load = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      ld      = ld | ~v_q[i];
      load[i] = ld;
    end
  end

  assign in_ready  = load[0];
  assign out_valid = v_q[DEPTH-1];
  assign out_data  = d_q[DEPTH-1];
  assign out_count = count_q;
  assign out_fire  = v_q[DEPTH-1] & out_ready;

  // Next-state: a loading stage takes its upstream word, or goes empty if there is none;
  // data registers change only when a word actually arrives.
  always_comb begin
    v_d = v_q;
    for (int i = 0; i < DEPTH; i++) begin
      d_d[i] = d_q[i];
    end
    if (load[0]) begin
      v_d[0] = in_valid;
      if (in_valid) begin
        d_d[0] = in_data ^ in_mask;
      end
    end
    for (int i = 1; i < DEPTH; i++) begin
      if (load[i]) begin
        v_d[i] = v_q[i-1];
        if (v_q[i-1]) begin
          d_d[i] = d_q[i-1];
        end
      end
    end
    count_d = out_fire ? count_q + COUNT_W'(1) : count_q;
  end

  // State registers; reset wins over any transfer in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q     <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        d_q[i] <= '0;
      end
    end else begin
      v_q     <= v_d;
      count_q <= count_d;
      for (int i = 0; i < DEPTH; i++) begin
        d_q[i] <= d_d[i];
      end
    end
  end

endmodule

// File: tb/tb_week6_ex1_not_pipe.sv
// tb/tb_week6_ex1_not_pipe.sv - directed bench for week6_ex1_not_pipe
module tb_week6_ex1_not_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [7:0] in_mask;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [3:0] out_count;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc_no   = 0;

  logic [7:0] got[$];
  int         got_cyc[$];
  logic [7:0] exp_q[$];

  week6_ex1_not_pipe #(.WIDTH(8), .DEPTH(2), .COUNT_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mask   (in_mask),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count)
  );

  always #5 clk = ~clk;

  // One clock cycle: drive at negedge, observe before the edge, log output transfers.
  task automatic cyc(input logic iv, input logic [7:0] id, input logic [7:0] im, input logic ordy,
                     output logic acc, output logic ot, output logic ird, output logic ov,
                     output logic [7:0] od, output logic [3:0] cnt);
    @(negedge clk);
    in_valid  = iv;
    in_data   = id;
    in_mask   = im;
    out_ready = ordy;
    #1;
    ird = in_ready;
    ov  = out_valid;
    od  = out_data;
    acc = iv & in_ready;
    ot  = out_valid & ordy;
    @(posedge clk);
    #1;
    cnt = out_count;
    if (ot) begin
      got.push_back(od);
      got_cyc.push_back(cyc_no);
    end
    cyc_no++;
  endtask

  task automatic start_scenario();
    got.delete();
    got_cyc.delete();
    cyc_no = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; in_data = 8'h55; in_mask = 8'hFF; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_checks++;
    if (out_data !== 8'h00) begin n_fail++; $display("FAIL reset_out_data: got %h expected 00", out_data); end
    n_checks++;
    if (out_count !== 4'd0) begin n_fail++; $display("FAIL reset_out_count: got %0d expected 0", out_count); end
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_not();
    logic acc, ot, ird, ov;
    logic [7:0] od;
    logic [3:0] cnt;
    start_scenario();
    cyc(1'b1, 8'h00, 8'hFF, 1'b1, acc, ot, ird, ov, od, cnt);
    n_checks++;
    if (acc !== 1'b1) begin n_fail++; $display("FAIL not_accept0: got %b expected 1", acc); end
    cyc(1'b1, 8'hA5, 8'hFF, 1'b1, acc, ot, ird, ov, od, cnt);
    n_checks++;
    if (acc !== 1'b1) begin n_fail++; $display("FAIL not_accept1: got %b expected 1", acc); end
    for (int c = 0; c < 10 && got.size() < 2; c++) cyc(1'b0, 8'h00, 8'h00, 1'b1, acc, ot, ird, ov, od, cnt);
    exp_q = '{8'hFF, 8'h5A};
    n_checks++;
    if (got.size() !== 2) begin n_fail++; $display("FAIL not_count_out: got %0d words expected 2", got.size()); end
    for (int i = 0; i < 2 && i < got.size(); i++) begin
      n_checks++;
      if (got[i] !== exp_q[i]) begin n_fail++; $display("FAIL not_data%0d: got %h expected %h", i, got[i], exp_q[i]); end
      n_checks++;
      if (got_cyc[i] !== 2 + i) begin n_fail++; $display("FAIL not_timing%0d: got cycle %0d expected %0d", i, got_cyc[i], 2 + i); end
    end
    n_checks++;
    if (out_count !== 4'd2) begin n_fail++; $display("FAIL not_out_count: got %0d expected 2", out_count); end
  endtask

  task automatic test_mask();
    logic acc, ot, ird, ov;
    logic [7:0] od;
    logic [3:0] cnt;
    start_scenario();
    cyc(1'b1, 8'h0F, 8'h00, 1'b1, acc, ot, ird, ov, od, cnt);
    cyc(1'b1, 8'h0F, 8'hF0, 1'b1, acc, ot, ird, ov, od, cnt);
    cyc(1'b1, 8'hFF, 8'h81, 1'b1, acc, ot, ird, ov, od, cnt);
    for (int c = 0; c < 10 && got.size() < 3; c++) cyc(1'b0, 8'h00, 8'h00, 1'b1, acc, ot, ird, ov, od, cnt);
    exp_q = '{8'h0F, 8'hFF, 8'h7E};
    n_checks++;
    if (got.size() !== 3) begin n_fail++; $display("FAIL mask_count_out: got %0d words expected 3", got.size()); end
    for (int i = 0; i < 3 && i < got.size(); i++) begin
      n_checks++;
      if (got[i] !== exp_q[i]) begin n_fail++; $display("FAIL mask_data%0d: got %h expected %h", i, got[i], exp_q[i]); end
    end
    n_checks++;
    if (out_count !== 4'd5) begin n_fail++; $display("FAIL mask_out_count: got %0d expected 5", out_count); end
  endtask

  task automatic test_backpressure();
    logic acc, ot, ird, ov;
    logic [7:0] od;
    logic [3:0] cnt;
    int sent;
    sent = 0;
    start_scenario();
    for (int c = 0; c < 30 && (got.size() < 6 || sent < 6); c++) begin
      cyc(sent < 6, 8'(sent + 1), 8'h00, c >= 5, acc, ot, ird, ov, od, cnt);
      if (acc) sent++;
      if (c >= 2 && c <= 4) begin
        n_checks++;
        if (ird !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready_c%0d: got %b expected 0", c, ird); end
        n_checks++;
        if (ov !== 1'b1) begin n_fail++; $display("FAIL bp_out_valid_c%0d: got %b expected 1", c, ov); end
        n_checks++;
        if (od !== 8'h01) begin n_fail++; $display("FAIL bp_out_data_c%0d: got %h expected 01", c, od); end
      end
    end
    exp_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    n_checks++;
    if (got.size() !== 6) begin n_fail++; $display("FAIL bp_count_out: got %0d words expected 6", got.size()); end
    for (int i = 0; i < 6 && i < got.size(); i++) begin
      n_checks++;
      if (got[i] !== exp_q[i]) begin n_fail++; $display("FAIL bp_data%0d: got %h expected %h", i, got[i], exp_q[i]); end
    end
    n_checks++;
    if (out_count !== 4'd11) begin n_fail++; $display("FAIL bp_out_count: got %0d expected 11", out_count); end
  endtask

  task automatic test_bubbles();
    logic acc, ot, ird, ov;
    logic [7:0] od;
    logic [3:0] cnt;
    logic [7:0] words[4];
    int sent;
    words = '{8'h11, 8'h22, 8'h33, 8'h44};
    sent = 0;
    start_scenario();
    for (int c = 0; c < 30 && (got.size() < 4 || sent < 4); c++) begin
      cyc((c % 2 == 0) && sent < 4, words[sent % 4], 8'h0F, (c < 8) ? (c % 2 == 1) : 1'b1,
          acc, ot, ird, ov, od, cnt);
      if (acc) sent++;
    end
    exp_q = '{8'h1E, 8'h2D, 8'h3C, 8'h4B};
    n_checks++;
    if (sent !== 4) begin n_fail++; $display("FAIL bub_accepts: got %0d expected 4", sent); end
    n_checks++;
    if (got.size() !== 4) begin n_fail++; $display("FAIL bub_count_out: got %0d words expected 4", got.size()); end
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      n_checks++;
      if (got[i] !== exp_q[i]) begin n_fail++; $display("FAIL bub_data%0d: got %h expected %h", i, got[i], exp_q[i]); end
    end
    n_checks++;
    if (out_count !== 4'd15) begin n_fail++; $display("FAIL bub_out_count: got %0d expected 15", out_count); end
  endtask

  task automatic test_reset_mid();
    logic acc, ot, ird, ov;
    logic [7:0] od;
    logic [3:0] cnt;
    start_scenario();
    cyc(1'b1, 8'hAA, 8'h00, 1'b0, acc, ot, ird, ov, od, cnt);
    n_checks++;
    if (acc !== 1'b1) begin n_fail++; $display("FAIL rmid_accept0: got %b expected 1", acc); end
    cyc(1'b1, 8'hBB, 8'h00, 1'b0, acc, ot, ird, ov, od, cnt);
    n_checks++;
    if (acc !== 1'b1) begin n_fail++; $display("FAIL rmid_accept1: got %b expected 1", acc); end
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b1; in_data = 8'hCC; in_mask = 8'h00; out_ready = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_out_valid: got %b expected 0", out_valid); end
    n_checks++;
    if (out_data !== 8'h00) begin n_fail++; $display("FAIL rmid_out_data: got %h expected 00", out_data); end
    n_checks++;
    if (out_count !== 4'd0) begin n_fail++; $display("FAIL rmid_out_count: got %0d expected 0", out_count); end
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_in_ready: got %b expected 1", in_ready); end
    start_scenario();
    cyc(1'b1, 8'h3C, 8'hFF, 1'b1, acc, ot, ird, ov, od, cnt);
    for (int c = 0; c < 10 && got.size() < 1; c++) cyc(1'b0, 8'h00, 8'h00, 1'b1, acc, ot, ird, ov, od, cnt);
    n_checks++;
    if (got.size() !== 1) begin n_fail++; $display("FAIL rmid_count_out: got %0d words expected 1", got.size()); end
    if (got.size() >= 1) begin
      n_checks++;
      if (got[0] !== 8'hC3) begin n_fail++; $display("FAIL rmid_data: got %h expected c3", got[0]); end
      n_checks++;
      if (got_cyc[0] !== 2) begin n_fail++; $display("FAIL rmid_timing: got cycle %0d expected 2", got_cyc[0]); end
    end
    n_checks++;
    if (out_count !== 4'd1) begin n_fail++; $display("FAIL rmid_out_count_after: got %0d expected 1", out_count); end
  endtask

  task automatic test_counter_wrap();
    logic acc, ot, ird, ov;
    logic [7:0] od;
    logic [3:0] cnt;
    int sent;
    int tcount;
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sent = 0;
    tcount = 0;
    start_scenario();
    for (int c = 0; c < 40 && got.size() < 17; c++) begin
      cyc(sent < 17, 8'(sent), 8'h00, 1'b1, acc, ot, ird, ov, od, cnt);
      if (acc) sent++;
      if (ot) begin
        tcount++;
        n_checks++;
        if (cnt !== 4'(tcount % 16)) begin
          n_fail++;
          $display("FAIL wrap_count_after_%0d: got %0d expected %0d", tcount, cnt, tcount % 16);
        end
      end
    end
    n_checks++;
    if (got.size() !== 17) begin n_fail++; $display("FAIL wrap_count_out: got %0d words expected 17", got.size()); end
    for (int i = 0; i < 17 && i < got.size(); i++) begin
      n_checks++;
      if (got[i] !== 8'(i)) begin n_fail++; $display("FAIL wrap_data%0d: got %h expected %h", i, got[i], 8'(i)); end
    end
    if (got_cyc.size() == 17) begin
      n_checks++;
      if (got_cyc[16] - got_cyc[0] !== 16) begin
        n_fail++;
        $display("FAIL wrap_throughput: got span %0d expected 16", got_cyc[16] - got_cyc[0]);
      end
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_mask = 8'h00; out_ready = 1'b0;
    test_reset();
    test_not();
    test_mask();
    test_backpressure();
    test_bubbles();
    test_reset_mid();
    test_counter_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
